// File: rtl/ultra_scan_ctrl.sv
// ultra_scan_ctrl
// Multi-channel ultrasonic scan controller. Each pass waits for a qualified
// driver status word, drives a burst on the active channel, ignores the
// ring-down window, listens for a debounced echo and updates a per-channel
// hit/miss hysteresis that drives the ct LED outputs. LED feedback pulses on
// ct1 are synchronised and counted independently of the scan.
//
// Ports:
//   gclk          system clock
//   rst           synchronous reset, active-high
//   spi_data_out  16-bit driver status word, valid when done=1
//   done          one-cycle strobe marking a completed SPI frame
//   out3 / out4   per-channel comparator / echo-detect inputs
//   ct1           asynchronous LED feedback input
//   burst_en      one-hot burst drive for the active channel
//   ct            per-channel object-present LED control
//   cur_ch        channel currently being scanned
//   busy          high from the first burst cycle through evaluation
//   fault         sticky permanent fault (cleared only by rst)
//   led_cnt       saturating count of ct1 rising edges
//
// Status handshake: a word is offered by a one-cycle done strobe with no
// back-pressure; the newest word always overwrites the held one, and a word
// arriving in the same cycle the scan consumes the held one survives.
module ultra_scan_ctrl #(
  parameter int N_CH          = 2,
  parameter int BURST_CYCLES  = 16,
  parameter int BLANK_CYCLES  = 32,
  parameter int LISTEN_CYCLES = 256,
  parameter int HIT_THRESH    = 4,
  parameter int CONFIRM       = 2,
  parameter int MAX_RETRY     = 3,
  parameter int USE_OUT3      = 1,
  parameter int CNT_W         = 16
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic [15:0]      spi_data_out,
  input  logic             done,
  input  logic [N_CH-1:0]  out3,
  input  logic [N_CH-1:0]  out4,
  input  logic             ct1,
  output logic [N_CH-1:0]  burst_en,
  output logic [N_CH-1:0]  ct,
  output logic [2:0]       cur_ch,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] led_cnt
);

  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int MAXA = (BURST_CYCLES > BLANK_CYCLES) ? BURST_CYCLES : BLANK_CYCLES;
  localparam int MAXC = (MAXA > LISTEN_CYCLES) ? MAXA : LISTEN_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);
  localparam int HW   = $clog2(HIT_THRESH + 1);
  localparam int KW   = $clog2(CONFIRM + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_BURST, S_BLANK, S_LISTEN, S_EVAL, S_NEXT, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      stat_q, stat_d;
  logic             sv_q, sv_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [HW-1:0]    run_q, run_d;
  logic             hit_q, hit_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [KW-1:0]    hc_q [N_CH];
  logic [KW-1:0]    hc_d [N_CH];
  logic [KW-1:0]    mc_q [N_CH];
  logic [KW-1:0]    mc_d [N_CH];
  logic [N_CH-1:0]  ct_q, ct_d;
  logic [N_CH-1:0]  burst_q, burst_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] led_q, led_d;

  logic             ready, flt, echo_bit, ct1_rise;
  logic [N_CH-1:0]  echo_vec;
  logic [RW-1:0]    retry_inc;
  logic             unused_stat;

  assign ready       = stat_q[14] & (stat_q[10:9] == 2'b11);
  assign flt         = |stat_q[4:2];
  assign echo_vec    = (USE_OUT3 != 0) ? (out4 & out3) : out4;
  assign echo_bit    = echo_vec[ch_q];
  assign retry_inc   = retry_q + RW'(1);
  // sync_q[1] is the second synchroniser stage, sync_q[2] its previous value.
  assign ct1_rise    = sync_q[1] & ~sync_q[2];
  assign unused_stat = ^{stat_q[15], stat_q[13:11], stat_q[8:5], stat_q[1:0]};

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    sv_d    = sv_q;
    retry_d = retry_q;
    tmr_d   = tmr_q;
    run_d   = run_q;
    hit_d   = hit_q;
    ch_d    = ch_q;
    hc_d    = hc_q;
    mc_d    = mc_q;
    ct_d    = ct_q;

    case (state_q)
      S_IDLE: state_d = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (sv_q) begin
          sv_d = 1'b0;
          if (flt) begin
            retry_d = retry_inc;
            if (retry_inc == RW'(MAX_RETRY)) state_d = S_FAULT;
          end else if (ready) begin
            retry_d = '0;
            tmr_d   = '0;
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (tmr_q == TW'(BURST_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_BLANK;
        end else tmr_d = tmr_q + TW'(1);
      end
      S_BLANK: begin
        if (tmr_q == TW'(BLANK_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_LISTEN;
        end else tmr_d = tmr_q + TW'(1);
      end
      S_LISTEN: begin
        // run saturates at the threshold so it cannot wrap on long echoes.
        if (echo_bit) run_d = (run_q == HW'(HIT_THRESH)) ? run_q : run_q + HW'(1);
        else          run_d = '0;
        if (run_d == HW'(HIT_THRESH)) hit_d = 1'b1;
        if (tmr_q == TW'(LISTEN_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_EVAL;
        end else tmr_d = tmr_q + TW'(1);
      end
      S_EVAL: begin
        if (hit_q) begin
          if (hc_q[ch_q] != KW'(CONFIRM)) hc_d[ch_q] = hc_q[ch_q] + KW'(1);
          mc_d[ch_q] = '0;
          if (hc_d[ch_q] == KW'(CONFIRM)) ct_d[ch_q] = 1'b1;
        end else begin
          if (mc_q[ch_q] != KW'(CONFIRM)) mc_d[ch_q] = mc_q[ch_q] + KW'(1);
          hc_d[ch_q] = '0;
          if (mc_d[ch_q] == KW'(CONFIRM)) ct_d[ch_q] = 1'b0;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        ch_d    = (ch_q == CW'(N_CH - 1)) ? '0 : ch_q + CW'(1);
        hit_d   = 1'b0;
        run_d   = '0;
        state_d = S_WAIT_RDY;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Capture last so a new word wins over the consume-clear above.
    if (done) begin
      stat_d = spi_data_out;
      sv_d   = 1'b1;
    end

    // Registered outputs are derived from the next state so they line up
    // with state_q in the cycle they are visible.
    burst_d = '0;
    if (state_d == S_BURST) burst_d[ch_q] = 1'b1;
    busy_d  = (state_d == S_BURST) || (state_d == S_BLANK) ||
              (state_d == S_LISTEN) || (state_d == S_EVAL);
    fault_d = (state_d == S_FAULT);

    sync_d = {sync_q[1:0], ct1};
    led_d  = (ct1_rise && (led_q != '1)) ? led_q + CNT_W'(1) : led_q;
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stat_q  <= '0;
      sv_q    <= 1'b0;
      retry_q <= '0;
      tmr_q   <= '0;
      run_q   <= '0;
      hit_q   <= 1'b0;
      ch_q    <= '0;
      hc_q    <= '{default: '0};
      mc_q    <= '{default: '0};
      ct_q    <= '0;
      burst_q <= '0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      sync_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      sv_q    <= sv_d;
      retry_q <= retry_d;
      tmr_q   <= tmr_d;
      run_q   <= run_d;
      hit_q   <= hit_d;
      ch_q    <= ch_d;
      hc_q    <= hc_d;
      mc_q    <= mc_d;
      ct_q    <= ct_d;
      burst_q <= burst_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      sync_q  <= sync_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    cur_ch         = '0;
    cur_ch[CW-1:0] = ch_q;
  end

  assign burst_en = burst_q;
  assign ct       = ct_q;
  assign busy     = busy_q;
  assign fault    = fault_q;
  assign led_cnt  = led_q;

endmodule

// File: doc/ultra_scan_ctrl.md
Name: ultra_scan_ctrl

Overview:
Multi-channel ultrasonic detection controller and the parametrised successor of the single-channel burst/detect block. It qualifies transducer-driver readiness and faults from 16-bit SPI status words. It scans N_CH sensors round-robin, each with a burst, a blanking window and a listen window. Echoes on out3/out4 are debounced into per-channel hits, hysteresis-confirmed hits drive the ct LED outputs, and ct1 LED feedback pulses are counted.

Parameters:
N_CH, 2, number of sensor channels (1..8)
BURST_CYCLES, 16, gclk cycles burst_en is held per measurement
BLANK_CYCLES, 32, ring-down cycles ignored after burst
LISTEN_CYCLES, 256, echo listen window length
HIT_THRESH, 4, consecutive qualified-echo cycles that make a hit (>=1)
CONFIRM, 2, consecutive hits to set ct, or consecutive misses to clear ct (>=1)
MAX_RETRY, 3, faulted status words tolerated before permanent FAULT
USE_OUT3, 1, 1: echo = out4 & out3; 0: echo = out4
CNT_W, 16, width of LED feedback counter

Ports:
gclk  in  1  system clock
rst  in  1  synchronous reset, active-high
spi_data_out  in  16  status word from SPI master, valid when done=1
done  in  1  one-cycle strobe: SPI frame complete
out3  in  N_CH  per-channel stability/threshold comparator (active-high)
out4  in  N_CH  per-channel echo detect (active-high)
ct1  in  1  LED feedback, asynchronous
burst_en  out  N_CH  burst drive, one-hot on the active channel
ct  out  N_CH  object-present LED control
cur_ch  out  3  channel currently scanned
busy  out  1  high in BURST, BLANK, LISTEN, EVAL
fault  out  1  sticky permanent fault
led_cnt  out  CNT_W  ct1 rising-edge count, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, cur_ch=0, status_valid=0, retry=0, all confirm counters 0.
- Status capture: on done=1, register spi_data_out into stat and set status_valid. ready = stat[14] & (stat[10:9]==2'b11). flt = |stat[4:2] (bit4 PULSE_NUM_FLT, bit3 DRV_PULSE_FLT, bit2 EE_CRC_FLT).
- FSM:
  - IDLE -> WAIT_RDY after 1 cycle.
  - WAIT_RDY, status_valid & flt: retry++ and clear status_valid. If the new retry==MAX_RETRY -> FAULT; else stay.
  - WAIT_RDY, status_valid & ready & !flt: retry=0, clear status_valid, -> BURST.
  - WAIT_RDY, status_valid & !ready & !flt: clear status_valid, stay.
  - BURST: burst_en[cur_ch]=1 for exactly BURST_CYCLES cycles, starting the cycle after the WAIT_RDY decision. -> BLANK.
  - BLANK: BLANK_CYCLES cycles; echo is ignored. -> LISTEN.
  - LISTEN: LISTEN_CYCLES cycles. run increments while echo[cur_ch]=1 and resets to 0 on echo=0. hit latches once run reaches HIT_THRESH. -> EVAL.
  - EVAL (1 cycle): on hit, hc[cur_ch]++ (saturating at CONFIRM) and mc[cur_ch]=0; on miss, the mirror. ct[cur_ch] is set when hc reaches CONFIRM and cleared when mc reaches CONFIRM; otherwise ct holds. -> NEXT.
  - NEXT (1 cycle): cur_ch = (cur_ch==N_CH-1) ? 0 : cur_ch+1; clear hit/run. -> WAIT_RDY.
  - FAULT: fault=1, burst_en=0, ct frozen. Leaves only on rst.
- done during BURST/BLANK/LISTEN/EVAL/NEXT still captures. A word captured in this window is evaluated in the next WAIT_RDY.
- done in the same cycle WAIT_RDY clears status_valid: the capture wins (status_valid stays 1 with the new word).
- ct1: 2-FF synchronizer, then rising-edge detect. led_cnt++ per edge and saturates at all-ones. It counts in every state except reset.
- rst asserted mid-burst: burst_en drops on the next gclk edge.
- Output latency: all outputs registered. ct updates the cycle after EVAL.

Test Plan:
1. Reset, then done with 16'h4600 -> burst_en=2'b01 for 16 cycles starting 1 cycle after decision; no echo -> ct=0, cur_ch=1 after NEXT.
2. Ready words on every pass; out4=out3=1 on ch0 for 4 consecutive LISTEN cycles in 2 successive ch0 measurements -> ct[0]=1 after 2nd EVAL; 2 echo-free ch0 measurements -> ct[0]=0.
3. Echo of 3 cycles, gap, 3 cycles (HIT_THRESH=4) -> no hit. Echo held only during BLANK -> no hit.
4. Three consecutive done words 16'h4610 (PULSE_NUM_FLT) -> fault=1 after the 3rd, burst_en stays 0. A fault, then 16'h4600 -> retry resets and burst proceeds.
5. USE_OUT3=0, out3=0, out4=1 for 10 cycles -> hit counted. With USE_OUT3=1 -> no hit.
6. 5 ct1 pulses (≥3 cycles wide), including during FAULT -> led_cnt=5. CNT_W=2 with 5 pulses -> led_cnt=3. rst mid-BURST -> burst_en=0 next edge, all outputs at reset values.
